// File: rtl/noc_router_param.sv
// Parametrised NoC router: NPORTS byte-serial ports. Each input assembles whole
// packets into a small packet FIFO. Each output picks among the input FIFO heads
// addressed to it with a round-robin arbiter, then serialises the packet.
module noc_router_param #(
  parameter int NPORTS     = 4,
  parameter int BYTE_W     = 8,
  parameter int PKT_BYTES  = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int DEST_LSB   = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NPORTS-1:0]          free_outbound,
  input  logic [NPORTS-1:0]          put_inbound,
  input  logic [NPORTS*BYTE_W-1:0]   payload_inbound,
  output logic [NPORTS-1:0]          free_inbound,
  output logic [NPORTS-1:0]          put_outbound,
  output logic [NPORTS*BYTE_W-1:0]   payload_outbound
);

  localparam int DW    = $clog2(NPORTS);
  localparam int PKT_W = PKT_BYTES * BYTE_W;
  localparam int CW    = $clog2(PKT_BYTES);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(PKT_BYTES - 1);

  typedef enum logic {ST_IDLE, ST_SEND} ost_e;

  // Deserialiser state: byte counter and partially assembled packet (byte 0 in the LSBs)
  logic [CW-1:0]    dcnt_q [NPORTS];
  logic [CW-1:0]    dcnt_d [NPORTS];
  logic [PKT_W-1:0] asm_q  [NPORTS];
  logic [PKT_W-1:0] asm_d  [NPORTS];
  logic [NPORTS-1:0] push;

  // Per-input packet FIFOs
  logic [PKT_W-1:0] mem_q [NPORTS][FIFO_DEPTH];
  logic [PW-1:0]    rp_q  [NPORTS];
  logic [PW-1:0]    rp_d  [NPORTS];
  logic [PW-1:0]    wp_q  [NPORTS];
  logic [PW-1:0]    wp_d  [NPORTS];
  logic [NW-1:0]    cnt_q [NPORTS];
  logic [NW-1:0]    cnt_d [NPORTS];
  logic [NPORTS-1:0] pop;
  logic [PKT_W-1:0] head_pkt [NPORTS];
  logic [DW-1:0]    head_dst [NPORTS];

  // Per-output arbiter / serialiser
  ost_e             st_q   [NPORTS];
  ost_e             st_d   [NPORTS];
  logic [CW-1:0]    bcnt_q [NPORTS];
  logic [CW-1:0]    bcnt_d [NPORTS];
  logic [DW-1:0]    rr_q   [NPORTS];
  logic [DW-1:0]    rr_d   [NPORTS];
  logic [PKT_W-1:0] sh_q   [NPORTS];
  logic [PKT_W-1:0] sh_d   [NPORTS];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) >= FIFO_DEPTH - 1) return '0;
    return p + PW'(1);
  endfunction

  // Deserialise inbound bytes; push the completed packet on its last byte
  always_comb begin
    push = '0;
    for (int i = 0; i < NPORTS; i++) begin
      dcnt_d[i] = dcnt_q[i];
      asm_d[i]  = asm_q[i];
      if (put_inbound[i]) begin
        asm_d[i][int'(dcnt_q[i])*BYTE_W +: BYTE_W] = payload_inbound[i*BYTE_W +: BYTE_W];
        if (dcnt_q[i] == LAST) begin
          dcnt_d[i] = '0;
          push[i]   = 1'b1;
        end else begin
          dcnt_d[i] = dcnt_q[i] + CW'(1);
        end
      end
    end
  end

  // FIFO head and its destination port (out-of-range fields wrap modulo NPORTS)
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      head_pkt[i] = mem_q[i][rp_q[i]];
      head_dst[i] = DW'(int'(head_pkt[i][DEST_LSB +: DW]) % NPORTS);
    end
  end

  // Per-output round-robin grant and serialiser sequencing
  always_comb begin
    logic found;
    int   gnt;
    int   idx;
    pop = '0;
    for (int o = 0; o < NPORTS; o++) begin
      st_d[o]   = st_q[o];
      bcnt_d[o] = bcnt_q[o];
      rr_d[o]   = rr_q[o];
      sh_d[o]   = sh_q[o];
      found     = 1'b0;
      gnt       = 0;
      idx       = 0;
      if (st_q[o] == ST_SEND) begin
        if (bcnt_q[o] == LAST) begin
          st_d[o]   = ST_IDLE;
          bcnt_d[o] = '0;
        end else begin
          bcnt_d[o] = bcnt_q[o] + CW'(1);
        end
      end
      // A new grant may land on the edge that ends the previous packet's last byte
      if (free_outbound[o] && (st_q[o] == ST_IDLE || bcnt_q[o] == LAST)) begin
        for (int k = 0; k < NPORTS; k++) begin
          idx = (int'(rr_q[o]) + k) % NPORTS;
          if (!found && cnt_q[idx] != '0 && head_dst[idx] == DW'(o)) begin
            found = 1'b1;
            gnt   = idx;
          end
        end
      end
      if (found) begin
        st_d[o]   = ST_SEND;
        bcnt_d[o] = '0;
        rr_d[o]   = DW'((gnt + 1) % NPORTS);
        sh_d[o]   = head_pkt[gnt];
        pop[gnt]  = 1'b1;
      end
    end
  end

  // FIFO pointer/occupancy update; push and pop on one edge leave the count unchanged
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      rp_d[i]  = rp_q[i];
      wp_d[i]  = wp_q[i];
      cnt_d[i] = cnt_q[i];
      if (push[i]) wp_d[i] = ptr_inc(wp_q[i]);
      if (pop[i])  rp_d[i] = ptr_inc(rp_q[i]);
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + NW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - NW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Port outputs: free counts a packet being assembled; idle outputs drive zero
  always_comb begin
    free_inbound     = '0;
    put_outbound     = '0;
    payload_outbound = '0;
    for (int i = 0; i < NPORTS; i++) begin
      free_inbound[i] = (int'(cnt_q[i]) + ((dcnt_q[i] != '0) ? 1 : 0)) < FIFO_DEPTH;
      if (st_q[i] == ST_SEND) begin
        put_outbound[i] = 1'b1;
        payload_outbound[i*BYTE_W +: BYTE_W] = sh_q[i][int'(bcnt_q[i])*BYTE_W +: BYTE_W];
      end
    end
  end

  // Control state registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPORTS; i++) begin
        dcnt_q[i] <= '0;
        rp_q[i]   <= '0;
        wp_q[i]   <= '0;
        cnt_q[i]  <= '0;
        st_q[i]   <= ST_IDLE;
        bcnt_q[i] <= '0;
        rr_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        rp_q[i]   <= rp_d[i];
        wp_q[i]   <= wp_d[i];
        cnt_q[i]  <= cnt_d[i];
        st_q[i]   <= st_d[i];
        bcnt_q[i] <= bcnt_d[i];
        rr_q[i]   <= rr_d[i];
      end
    end
  end

  // Packet data storage; contents are only observed when qualified by control state
  always_ff @(posedge clock) begin
    for (int i = 0; i < NPORTS; i++) begin
      asm_q[i] <= asm_d[i];
      sh_q[i]  <= sh_d[i];
      if (push[i]) mem_q[i][wp_q[i]] <= asm_d[i];
    end
  end

endmodule

// File: tb/tb_noc_router_param.sv
// Directed bench for noc_router_param (NPORTS=4, 4-byte packets, DEST_LSB=4).
module tb_noc_router_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  free_outbound = 4'hF;
  logic [3:0]  put_inbound = 4'h0;
  logic [31:0] payload_inbound = 32'h0;
  logic [3:0]  free_inbound;
  logic [3:0]  put_outbound;
  logic [31:0] payload_outbound;

  noc_router_param #(
    .NPORTS(4), .BYTE_W(8), .PKT_BYTES(4), .FIFO_DEPTH(2), .DEST_LSB(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .free_outbound(free_outbound),
    .put_inbound(put_inbound),
    .payload_inbound(payload_inbound),
    .free_inbound(free_inbound),
    .put_outbound(put_outbound),
    .payload_outbound(payload_outbound)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Output capture, sampled on the falling edge
  logic [7:0] cap_b [4][64];
  int         cap_c [4][64];
  int         cap_n [4];
  logic       clr_cap = 1'b0;

  always @(negedge clock) begin
    for (int o = 0; o < 4; o++) begin
      if (clr_cap) cap_n[o] <= 0;
      else if (put_outbound[o] && cap_n[o] < 64) begin
        cap_b[o][cap_n[o]] <= payload_outbound[o*8 +: 8];
        cap_c[o][cap_n[o]] <= cyc;
        cap_n[o] <= cap_n[o] + 1;
      end
    end
  end

  int total = 0;
  int bad = 0;
  logic [31:0] tx [4];
  int t_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pkt_of(input int o, input int k);
    return {cap_b[o][4*k], cap_b[o][4*k+1], cap_b[o][4*k+2], cap_b[o][4*k+3]};
  endfunction

  task automatic clear_cap();
    clr_cap = 1'b1;
    @(negedge clock);
    #1 clr_cap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    clear_cap();
  endtask

  // Drive one packet on every port in mask, byte 0 first (tx holds byte 0 in its MSBs)
  task automatic send_pkts(input logic [3:0] mask);
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      put_inbound = mask;
      for (int p = 0; p < 4; p++)
        payload_inbound[p*8 +: 8] = mask[p] ? tx[p][31-8*b -: 8] : 8'h00;
    end
    @(negedge clock);
    put_inbound = 4'h0;
    payload_inbound = 32'h0;
    t_last = cyc;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_put", {28'h0, put_outbound}, 32'h0);
    chk("rst_payload", payload_outbound, 32'h0);
    chk("rst_free", {28'h0, free_inbound}, 32'hF);
    reset = 1'b0;
    clear_cap();

    // Single packet 1 -> 2
    tx[1] = 32'h20AABBCC;
    send_pkts(4'b0010);
    chk("single_not_yet", {28'h0, put_outbound}, 32'h0);
    repeat (10) @(negedge clock);
    chk("single_len", cap_n[2], 4);
    chk("single_data", pkt_of(2, 0), 32'h20AABBCC);
    chk("single_latency", cap_c[2][0], t_last + 1);
    chk("single_contig", cap_c[2][3] - cap_c[2][0], 3);
    chk("single_others", cap_n[0] + cap_n[1] + cap_n[3], 0);

    // Contention: 0,1,3 -> 2 from a fresh round-robin pointer
    do_reset();
    tx[0] = 32'h20010203;
    tx[1] = 32'h21111213;
    tx[3] = 32'h23313233;
    send_pkts(4'b1011);
    repeat (20) @(negedge clock);
    chk("cont_len", cap_n[2], 12);
    chk("cont_pkt0", pkt_of(2, 0), 32'h20010203);
    chk("cont_pkt1", pkt_of(2, 1), 32'h21111213);
    chk("cont_pkt2", pkt_of(2, 2), 32'h23313233);
    chk("cont_nogap", cap_c[2][11] - cap_c[2][0], 11);
    chk("cont_start", cap_c[2][0], t_last + 1);
    clear_cap();

    // Backpressure on output 3, traffic from port 0
    free_outbound = 4'b0111;
    tx[0] = 32'h30A1A2A3;
    send_pkts(4'b0001);
    chk("bp_free_one", {31'h0, free_inbound[0]}, 32'h1);
    tx[0] = 32'h30B1B2B3;
    send_pkts(4'b0001);
    chk("bp_free_full", {31'h0, free_inbound[0]}, 32'h0);
    repeat (3) @(negedge clock);
    chk("bp_blocked", {31'h0, put_outbound[3]}, 32'h0);
    chk("bp_still_full", {31'h0, free_inbound[0]}, 32'h0);
    free_outbound = 4'hF;
    @(negedge clock);
    chk("bp_free_after_pop", {31'h0, free_inbound[0]}, 32'h1);
    chk("bp_sending", {31'h0, put_outbound[3]}, 32'h1);
    tx[0] = 32'h30C1C2C3;
    send_pkts(4'b0001);
    repeat (20) @(negedge clock);
    chk("bp_len", cap_n[3], 12);
    chk("bp_pkt0", pkt_of(3, 0), 32'h30A1A2A3);
    chk("bp_pkt1", pkt_of(3, 1), 32'h30B1B2B3);
    chk("bp_pkt2", pkt_of(3, 2), 32'h30C1C2C3);
    clear_cap();

    // Parallel paths 0 -> 1 and 2 -> 3
    tx[0] = 32'h10515253;
    tx[2] = 32'h30626364;
    send_pkts(4'b0101);
    repeat (10) @(negedge clock);
    chk("par_data1", pkt_of(1, 0), 32'h10515253);
    chk("par_data3", pkt_of(3, 0), 32'h30626364);
    chk("par_same_start", cap_c[1][0], cap_c[3][0]);
    chk("par_start", cap_c[1][0], t_last + 1);
    chk("par_lens", cap_n[1] + cap_n[3], 8);
    chk("par_others", cap_n[0] + cap_n[2], 0);
    clear_cap();

    // Destination wrap: header 0x50 carries field 1 in bits [5:4]
    tx[3] = 32'h50717273;
    send_pkts(4'b1000);
    repeat (10) @(negedge clock);
    chk("wrap_len", cap_n[1], 4);
    chk("wrap_data", pkt_of(1, 0), 32'h50717273);
    chk("wrap_others", cap_n[0] + cap_n[2] + cap_n[3], 0);
    clear_cap();

    // Reset during byte 2 of an outbound packet, with another packet parked for output 0
    free_outbound = 4'b1110;
    tx[0] = 32'h20D1D2D3;
    tx[3] = 32'h00E1E2E3;
    send_pkts(4'b1001);
    repeat (3) @(negedge clock);
    chk("mid_put", {31'h0, put_outbound[2]}, 32'h1);
    chk("mid_byte2", {24'h0, payload_outbound[23:16]}, 32'hD2);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_put", {28'h0, put_outbound}, 32'h0);
    chk("mid_rst_payload", payload_outbound, 32'h0);
    chk("mid_rst_free", {28'h0, free_inbound}, 32'hF);
    clear_cap();
    reset = 1'b0;
    free_outbound = 4'hF;
    repeat (15) @(negedge clock);
    chk("mid_no_stale", cap_n[0] + cap_n[1] + cap_n[2] + cap_n[3], 0);
    chk("mid_free_after", {28'h0, free_inbound}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
